dmem_responder: RTL and testbench

Responder end of the core's data-memory bus. It accepts word-wide MemRead/MemWrite requests issued by the multicycle core on dAddress/dWriteData, inserts a programmable number of wait states, and returns dReadData with a one-cycle dReady strobe. Illegal requests are answered with dErr. It sits between the core's data port and an internal word array, and replaces the zero-latency combinational data RAM.

---
 rtl/dmem_pkg.sv | 9 +
 rtl/dmem_responder_if.sv | 16 +
 rtl/dmem_array.sv | 20 ++
 rtl/dmem_responder.sv | 97 +++++++++
 tb/tb_dmem_responder.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;
  localparam int WORD_W   = 32;
  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 15;
  localparam logic [WORD_W-1:0] ALIGN_MASK = 32'h0000_0003;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/dmem_responder_if.sv
// Core data-port bus: request from the core, registered response from the responder.
interface dmem_responder_if;
  import dmem_pkg::*;
  logic              MemRead;
  logic              MemWrite;
  logic [WORD_W-1:0] dAddress;
  logic [WORD_W-1:0] dWriteData;
  logic [WORD_W-1:0] dReadData;
  logic              dReady;
  logic              dErr;

  modport master (output MemRead, MemWrite, dAddress, dWriteData,
                  input  dReadData, dReady, dErr);
  modport slave  (input  MemRead, MemWrite, dAddress, dWriteData,
                  output dReadData, dReady, dErr);
endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word array; read data registered and held between reads.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int AW = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout
);
  logic [WORD_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    if (re) dout <= mem[addr];
  end
endmodule

// File: rtl/dmem_responder.sv
// Wait-stated responder for the core's data bus with legality checking.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);
  localparam int AW = ADDR_WIDTH - 2;
  localparam logic [CNT_W-1:0] WAIT_LD =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [AW-1:0]     idx_q;
  logic [WORD_W-1:0] data_q;
  logic              rd_q, wr_q, ill_q;
  logic              rdy_q, err_q, rd_zero;

  logic              req, ill_in, in_idle, to_resp;
  logic [AW-1:0]     c_idx;
  logic [WORD_W-1:0] c_data, arr_dout;
  logic              c_rd, c_wr, c_ill;

  // With zero wait states the response edge is the capture edge, so the
  // array must see the live request in IDLE and the latched one afterwards.
  always_comb begin
    req     = bus.MemRead | bus.MemWrite;
    ill_in  = (bus.MemRead & bus.MemWrite)
            | (|(bus.dAddress & ALIGN_MASK))
            | (|(bus.dAddress >> ADDR_WIDTH));
    in_idle = (state == IDLE);
    c_idx   = in_idle ? bus.dAddress[ADDR_WIDTH-1:2] : idx_q;
    c_data  = in_idle ? bus.dWriteData : data_q;
    c_rd    = in_idle ? bus.MemRead    : rd_q;
    c_wr    = in_idle ? bus.MemWrite   : wr_q;
    c_ill   = in_idle ? ill_in         : ill_q;
    to_resp = (in_idle && req && (WAIT_CYCLES == 0))
            || ((state == WAIT) && (cnt == '0));
  end

  dmem_array #(.AW(AW)) u_arr (
    .clk  (clk),
    .we   (to_resp & c_wr & ~c_ill),
    .re   (to_resp & c_rd & ~c_ill),
    .addr (c_idx),
    .din  (c_data),
    .dout (arr_dout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ill_q   <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_zero <= 1'b1;
    end else begin
      rdy_q <= to_resp;
      err_q <= to_resp & c_ill;
      // Error responses force zero data; write responses keep the last read.
      if (to_resp) begin
        if (c_ill)     rd_zero <= 1'b1;
        else if (c_rd) rd_zero <= 1'b0;
      end
      case (state)
        IDLE: if (req) begin
          idx_q  <= bus.dAddress[ADDR_WIDTH-1:2];
          data_q <= bus.dWriteData;
          rd_q   <= bus.MemRead;
          wr_q   <= bus.MemWrite;
          ill_q  <= ill_in;
          cnt    <= WAIT_LD;
          state  <= (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dReady    = rdy_q;
  assign bus.dErr      = err_q;
  assign bus.dReadData = rd_zero ? '0 : arr_dout;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) against a word-array model.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if ifc2();
  dmem_responder_if ifc0();

  dmem_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(ifc2.slave));
  dmem_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(ifc0.slave));

  int checks = 0;
  int errors = 0;

  // Model state, index 1 = two wait states, index 0 = zero wait states
  logic [31:0] mem_m [2][128];
  logic [31:0] last_rd [2];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic        ee;
    logic [31:0] ed;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int s, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (s == 1) begin
      ifc2.MemRead = rd; ifc2.MemWrite = wr; ifc2.dAddress = a; ifc2.dWriteData = d;
    end else begin
      ifc0.MemRead = rd; ifc0.MemWrite = wr; ifc0.dAddress = a; ifc0.dWriteData = d;
    end
  endtask

  function automatic logic rdy(input int s);
    return (s == 1) ? ifc2.dReady : ifc0.dReady;
  endfunction
  function automatic logic errf(input int s);
    return (s == 1) ? ifc2.dErr : ifc0.dErr;
  endfunction
  function automatic logic [31:0] rdat(input int s);
    return (s == 1) ? ifc2.dReadData : ifc0.dReadData;
  endfunction

  // Behavioural reference: legality from the address rules, then a plain word array.
  task automatic model(input int s, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] ed, output logic ee);
    bit legal;
    legal = !(rd && wr) && (a[1:0] == 2'b00) && ((a >> 9) == 0);
    if (!legal) begin
      ee = 1'b1; ed = '0; last_rd[s] = '0;
    end else if (wr) begin
      mem_m[s][a[8:2]] = d; ee = 1'b0; ed = last_rd[s];
    end else begin
      ee = 1'b0; ed = mem_m[s][a[8:2]]; last_rd[s] = ed;
    end
  endtask

  // Drive at a negedge, count edges until dReady, optionally scramble inputs while waiting.
  task automatic txn(input int s, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input bit scr,
                     output logic [31:0] rdata, output logic err, output int lat);
    bit ok;
    ok = 0; lat = 0;
    drive(s, rd, wr, a, d);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (rdy(s)) begin ok = 1; break; end
      if (scr) drive(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
    end
    if (!ok) lat = -1;
    rdata = rdat(s);
    err   = errf(s);
    drive(s, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("single_strobe", {31'b0, rdy(s)}, 32'd0);
  endtask

  task automatic run_chk(input int s, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input bit scr, input string nm);
    logic [31:0] ed, rdata;
    logic ee, err;
    int lat;
    model(s, rd, wr, a, d, ed, ee);
    txn(s, rd, wr, a, d, scr, rdata, err, lat);
    chk({nm, "_lat"},  32'(lat), (s == 1) ? 32'd3 : 32'd1);
    chk({nm, "_err"},  {31'b0, err}, {31'b0, ee});
    chk({nm, "_data"}, rdata, ed);
  endtask

  initial begin
    logic [31:0] rdata, a;
    logic err;
    int lat, op;

    tbl[0]  = '{1'b0, 1'b1, 32'h010, 32'hDEADBEEF, 1'b0, 32'h00000000};
    tbl[1]  = '{1'b1, 1'b0, 32'h010, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 1'b0, 32'h102, 32'h0,        1'b1, 32'h00000000};
    tbl[3]  = '{1'b0, 1'b1, 32'h200, 32'h0BADF00D, 1'b1, 32'h00000000};
    tbl[4]  = '{1'b1, 1'b0, 32'h000, 32'h0,        1'b0, 32'hC0DE0000};
    tbl[5]  = '{1'b1, 1'b1, 32'h020, 32'hA5A5A5A5, 1'b1, 32'h00000000};
    tbl[6]  = '{1'b1, 1'b0, 32'h020, 32'h0,        1'b0, 32'hC0DE0008};
    tbl[7]  = '{1'b1, 1'b0, 32'h80000000, 32'h0,   1'b1, 32'h00000000};
    tbl[8]  = '{1'b1, 1'b0, 32'h1FC, 32'h0,        1'b0, 32'hC0DE007F};
    tbl[9]  = '{1'b0, 1'b1, 32'h1FC, 32'h5555AAAA, 1'b0, 32'hC0DE007F};
    tbl[10] = '{1'b1, 1'b0, 32'h1FC, 32'h0,        1'b0, 32'h5555AAAA};
    tbl[11] = '{1'b0, 1'b1, 32'h003, 32'h00000001, 1'b1, 32'h00000000};
    tbl[12] = '{1'b1, 1'b0, 32'h000, 32'h0,        1'b0, 32'hC0DE0000};

    drive(1, 1'b0, 1'b0, '0, '0);
    drive(0, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", {31'b0, rdy(s)},  32'd0);
      chk("rst_err",   {31'b0, errf(s)}, 32'd0);
      chk("rst_data",  rdat(s),          32'd0);
      last_rd[s] = '0;
    end
    rst = 1'b1;
    @(negedge clk);

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 128; i++)
        run_chk(s, 1'b0, 1'b1, 32'(i * 4), 32'hC0DE0000 | 32'(i), 0, "fill");

    for (int i = 0; i < 13; i++) begin
      logic [31:0] ed;
      logic ee;
      model(1, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, ed, ee);
      txn(1, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, 0, rdata, err, lat);
      chk($sformatf("tbl%0d_lat", i),  32'(lat), 32'd3);
      chk($sformatf("tbl%0d_err", i),  {31'b0, err}, {31'b0, tbl[i].ee});
      chk($sformatf("tbl%0d_data", i), rdata, tbl[i].ed);
    end

    // Zero wait states: two reads back to back, strobe every second cycle
    run_chk(0, 1'b0, 1'b1, 32'h000, 32'h11111111, 0, "pre0");
    run_chk(0, 1'b0, 1'b1, 32'h004, 32'h22222222, 0, "pre4");
    drive(0, 1'b1, 1'b0, 32'h000, '0);
    @(negedge clk);
    chk("b2b_rdy1",  {31'b0, rdy(0)}, 32'd1);
    chk("b2b_data1", rdat(0), 32'h11111111);
    drive(0, 1'b1, 1'b0, 32'h004, '0);
    @(negedge clk);
    chk("b2b_gap",   {31'b0, rdy(0)}, 32'd0);
    @(negedge clk);
    chk("b2b_rdy2",  {31'b0, rdy(0)}, 32'd1);
    chk("b2b_data2", rdat(0), 32'h22222222);
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("b2b_end",   {31'b0, rdy(0)}, 32'd0);
    last_rd[0] = 32'h22222222;

    // Inputs scrambled during WAIT must not affect the latched request
    run_chk(1, 1'b0, 1'b1, 32'h030, 32'h11223344, 1, "scr_wr");
    run_chk(1, 1'b1, 1'b0, 32'h030, '0, 0, "scr_rd30");
    run_chk(1, 1'b1, 1'b0, 32'h034, '0, 0, "scr_rd34");

    for (int s = 0; s < 2; s++)
      for (int n = 0; n < 150; n++) begin
        op = int'($urandom_range(0, 9));
        a  = {23'b0, 7'($urandom_range(0, 127)), 2'b00};
        if (op == 9)
          a = ($urandom_range(0, 1) != 0) ? (a | 32'($urandom_range(1, 3)))
                                           : (a | (32'd1 << $urandom_range(9, 31)));
        run_chk(s, (op < 4) || (op >= 8), (op >= 4 && op < 8) || op == 8 || (op == 9 && n[0]),
                a, $urandom, (s == 1) && ($urandom_range(0, 1) != 0), "rand");
      end

    // Reset during WAIT of a write: outputs clear at once and the write is lost
    run_chk(1, 1'b1, 1'b0, 32'h040, '0, 0, "pre_rst_rd");
    drive(1, 1'b0, 1'b1, 32'h040, 32'h12345678);
    @(posedge clk);
    @(negedge clk);
    chk("wait_ready", {31'b0, rdy(1)}, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_ready", {31'b0, rdy(1)},  32'd0);
    chk("async_rst_err",   {31'b0, errf(1)}, 32'd0);
    chk("async_rst_data",  rdat(1),          32'd0);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk);
    run_chk(1, 1'b1, 1'b0, 32'h040, '0, 0, "post_rst_rd");
    run_chk(0, 1'b1, 1'b0, 32'h004, '0, 0, "post_rst_rd0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
